tv80_alu16_seq: RTL and testbench
=================================

# tv80_alu16_seq

Two-pass sequencer that executes the 16-bit register-pair arithmetic group (ADD/ADC/SBC/SUB rr,rr) on the 8-bit CPU ALU. Latches a 16-bit request, drives the ALU for the low byte, then the high byte with carry chaining, assembles Z80-correct 16-bit flags, and returns result plus flags with a done pulse. Sits between instruction control and the ALU; the ALU stays purely combinational.

## Interface
- `Flag_C`, `Flag_N`, `Flag_P`, `Flag_X`, `Flag_H`, `Flag_Y`, `Flag_Z`, `Flag_S`: defaults 0–7; bit positions in F.
- `clk  in  1`: sole clock; all state changes on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `start  in  1`: request strobe; accepted only in IDLE.
- `op  in  2`: 00 ADD, 01 ADC, 10 SBC, 11 SUB (no borrow-in).
- `opa`, `opb  in  16`: operands, A minus/plus B.
- `f_in  in  8`: flags at request time.
- `busy  out  1`: high in LO and HI.
- `done  out  1`: one-cycle pulse, result valid.
- `result  out  16`: registered 16-bit result.
- `f_out  out  8`: registered 16-bit flags.
- `alu_op  out  4`: ALU opcode.
- `alu_arith16`, `alu_z16  out  1`: ALU 16-bit flag modes.
- `alu_busa`, `alu_busb  out  8`: ALU operands.
- `alu_f_in  out  8`: ALU flag input.
- `alu_q  in  8`: ALU result.
- `alu_f  in  8`: ALU flag output.

## Operation
- States: IDLE → LO → HI → DONE → IDLE. IDLE→LO only on `start`=1; other transitions unconditional.
- At acceptance: latch `op`, `opa`, `opb`, `f_in`; later input changes do not affect the operation.
- LO drive:
  - `alu_busa`/`alu_busb` = low bytes; `alu_f_in` = latched f_in; `alu_z16`=0.
  - `alu_op` = 0000 (ADD), 0001 (ADC), 0011 (SBC), 0010 (SUB).
  - `alu_arith16` = 1 for ADD only.
  - End of cycle: capture `alu_q` into result low byte, `alu_f` into flag_lo.
- HI drive:
  - Buses = high bytes; `alu_f_in` = flag_lo (carries C and low-byte Z).
  - `alu_op` = 0001 for ADD/ADC, 0011 for SBC/SUB.
  - `alu_arith16` = 1 for ADD only; `alu_z16` = 1 for ADC/SBC/SUB, 0 for ADD.
  - End of cycle: capture `alu_q` into result high byte, `alu_f` into `f_out`.
- Resulting flags:
  - ADD: S/Z/P preserved from f_in.
  - ADC/SBC/SUB: Z is true 16-bit zero; S, P(V), and H come from the high byte.
  - C is bit 15 carry (or borrow). N is per op. X/Y come from the high result byte.
- Outside LO/HI, all `alu_*` outputs are 0.
- Sticky outputs: `result` and `f_out` change only at the end of HI and hold otherwise.

## Timing
- Start sampled at edge E0 → LO in cycle E0–E1, HI in E1–E2, `done`=1 in E2–E3, IDLE again at E3. Latency 3 cycles; throughput one op per 4 cycles.
- `start` is ignored while in LO, HI, or DONE; no queueing. If `start` is held high, it is accepted on the first IDLE cycle.
- `busy` and `done` are never high together.
- Reset values: state IDLE; `busy`, `done`, `result`, `f_out`, flag_lo all 0; `alu_*` outputs 0.
- Reset mid-operation (LO, HI, or DONE): next cycle is IDLE with all outputs at reset values. No `done` is produced and no partial result is exposed.

## Test plan
- ADD, opa=0x0FFF, opb=0x0001, f_in=0xC4 → `done` exactly 3 cycles after start; result=0x1000, f_out=0xD4.
- ADC, opa=0xFFFF, opb=0x0000, f_in=0x01 → result=0x0000, f_out=0x51 (Z from both bytes, H, C).
- SBC, opa=0x8000, opb=0x0001, f_in=0x00 → result=0x7FFF, f_out=0x3E (V, N, H, X, Y set; C clear). LO drives alu_op=0011; HI drives `alu_f_in` C=1.
- SUB (op=11), opa=opb=0x1234, f_in=0x01 → result=0x0000, f_out=0x42 (incoming C ignored).
- Handshake: hold `start` high for 10 cycles with changing operands. Each accepted op uses the operands present at its IDLE acceptance; `done` pulses every 4 cycles; no start is accepted in LO, HI, or DONE.
- Assert `reset` during HI of an ADC → next cycle: `busy`=0, `done`=0, `result`=0, `f_out`=0. No `done` pulse follows; a new start then completes normally.

Source files
------------

// File: rtl/tv80_alu16_seq.sv
// tv80_alu16_seq: runs the 16-bit register-pair arithmetic group
// (ADD/ADC/SBC/SUB rr,rr) as two passes through the 8-bit combinational ALU,
// low byte first, then high byte with the carry and low-byte Z chained in.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; request latched on the accepting edge
// S_LO   | ALU driven with low bytes; low result byte and flags captured
// S_HI   | ALU driven with high bytes; result and f_out updated
// S_DONE | one-cycle done pulse, result/f_out valid
module tv80_alu16_seq #(
    parameter int Flag_C = 0,
    parameter int Flag_N = 1,
    parameter int Flag_P = 2,
    parameter int Flag_X = 3,
    parameter int Flag_H = 4,
    parameter int Flag_Y = 5,
    parameter int Flag_Z = 6,
    parameter int Flag_S = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  f_out,
    output logic [3:0]  alu_op,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_f_in,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f
);

    // The flag word is produced entirely by the ALU; the positions only have
    // to form a permutation of 0..7 for the chained F register to make sense.
    localparam int FLAG_MAP = (1 << Flag_C) | (1 << Flag_N) | (1 << Flag_P) | (1 << Flag_X)
                            | (1 << Flag_H) | (1 << Flag_Y) | (1 << Flag_Z) | (1 << Flag_S);

    if (FLAG_MAP != 255) begin : g_bad_flag_map
        $error("tv80_alu16_seq: flag positions must be distinct values 0..7");
    end

    localparam logic [1:0] OP_ADD = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_op;
    logic [15:0] r_opa;
    logic [15:0] r_opb;
    logic [7:0]  r_f_in;
    logic [7:0]  r_q_lo;
    logic [7:0]  r_flag_lo;
    logic        w_is_add;

    assign w_is_add = (r_op == OP_ADD);
    assign busy     = (r_state == S_LO) || (r_state == S_HI);
    assign done     = (r_state == S_DONE);

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state and ALU drive; ALU inputs are held at zero outside LO/HI
    always_comb begin
        w_state_nxt = r_state;
        alu_op      = 4'b0000;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_busa    = 8'h00;
        alu_busb    = 8'h00;
        alu_f_in    = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LO;
                end
            end
            S_LO: begin
                w_state_nxt = S_HI;
                alu_busa    = r_opa[7:0];
                alu_busb    = r_opb[7:0];
                alu_f_in    = r_f_in;
                // ADD->ADD, ADC->ADC, SBC->SBC, SUB->SUB (no borrow-in on the low byte)
                alu_op      = {2'b00, r_op[1], r_op[1] ^ r_op[0]};
                alu_arith16 = w_is_add;
            end
            S_HI: begin
                w_state_nxt = S_DONE;
                alu_busa    = r_opa[15:8];
                alu_busb    = r_opb[15:8];
                alu_f_in    = r_flag_lo;
                // high byte always consumes the low-byte carry/borrow
                alu_op      = r_op[1] ? 4'b0011 : 4'b0001;
                alu_arith16 = w_is_add;
                alu_z16     = !w_is_add;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // request latch, low-byte capture, and sticky result/flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= 2'b00;
            r_opa     <= 16'h0000;
            r_opb     <= 16'h0000;
            r_f_in    <= 8'h00;
            r_q_lo    <= 8'h00;
            r_flag_lo <= 8'h00;
            result    <= 16'h0000;
            f_out     <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_opa  <= opa;
                        r_opb  <= opb;
                        r_f_in <= f_in;
                    end
                end
                S_LO: begin
                    r_q_lo    <= alu_q;
                    r_flag_lo <= alu_f;
                end
                S_HI: begin
                    result <= {alu_q, r_q_lo};
                    f_out  <= alu_f;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq: a behavioural 8-bit ALU closes the loop, a 16-bit
// reference model and fixed vectors feed a scoreboard checked on done.
module tb_tv80_alu16_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [7:0]  f_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  f_out;
    logic [3:0]  alu_op;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_busa;
    logic [7:0]  alu_busb;
    logic [7:0]  alu_f_in;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f;

    int checks = 0;
    int errors = 0;
    logic [23:0] sb_q[$];

    logic [1:0]  t_op   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [15:0] t_opa  [4] = '{16'h0FFF, 16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] t_opb  [4] = '{16'h0001, 16'h0000, 16'h0001, 16'h1234};
    logic [7:0]  t_fin  [4] = '{8'hC4, 8'h01, 8'h00, 8'h01};
    logic [15:0] t_res  [4] = '{16'h1000, 16'h0000, 16'h7FFF, 16'h0000};
    logic [7:0]  t_fout [4] = '{8'hD4, 8'h51, 8'h3E, 8'h42};

    tv80_alu16_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .f_in(f_in), .busy(busy), .done(done), .result(result), .f_out(f_out),
        .alu_op(alu_op), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
        .alu_busa(alu_busa), .alu_busb(alu_busb), .alu_f_in(alu_f_in),
        .alu_q(alu_q), .alu_f(alu_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural 8-bit ALU (ADD/ADC/SUB/SBC with 16-bit flag modes)
    logic [8:0] m_sum;
    logic [4:0] m_nib;
    logic       m_cin;
    logic       m_v;
    always_comb begin
        m_cin = alu_op[0] & alu_f_in[0];
        if (alu_op[1] == 1'b0) begin
            m_sum = {1'b0, alu_busa} + {1'b0, alu_busb} + {8'd0, m_cin};
            m_nib = {1'b0, alu_busa[3:0]} + {1'b0, alu_busb[3:0]} + {4'd0, m_cin};
            m_v   = (alu_busa[7] == alu_busb[7]) && (m_sum[7] != alu_busa[7]);
        end else begin
            m_sum = {1'b0, alu_busa} - {1'b0, alu_busb} - {8'd0, m_cin};
            m_nib = {1'b0, alu_busa[3:0]} - {1'b0, alu_busb[3:0]} - {4'd0, m_cin};
            m_v   = (alu_busa[7] != alu_busb[7]) && (m_sum[7] != alu_busa[7]);
        end
        alu_q = m_sum[7:0];
        alu_f = {m_sum[7], (m_sum[7:0] == 8'd0) && (!alu_z16 || alu_f_in[6]), m_sum[5],
                 m_nib[4], m_sum[3], m_v, alu_op[1], m_sum[8]};
        if (alu_arith16) begin
            alu_f[7] = alu_f_in[7];
            alu_f[6] = alu_f_in[6];
            alu_f[2] = alu_f_in[2];
        end
        if (alu_op[3:2] != 2'b00) begin
            alu_q = 8'h00;
            alu_f = 8'h00;
        end
    end

    // direct 16-bit reference: {flags, result}
    function automatic logic [23:0] ref16(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] f);
        logic [16:0] r;
        logic [12:0] h;
        logic        cin;
        logic        v;
        logic [7:0]  fo;
        cin = (o == 2'b01 || o == 2'b10) ? f[0] : 1'b0;
        if (o[1] == 1'b0) begin
            r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            h = {1'b0, a[11:0]} + {1'b0, b[11:0]} + {12'd0, cin};
            v = (a[15] == b[15]) && (r[15] != a[15]);
        end else begin
            r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
            h = {1'b0, a[11:0]} - {1'b0, b[11:0]} - {12'd0, cin};
            v = (a[15] != b[15]) && (r[15] != a[15]);
        end
        fo = {r[15], r[15:0] == 16'd0, r[13], h[12], r[11], v, o[1], r[16]};
        if (o == 2'b00) begin
            fo[7] = f[7];
            fo[6] = f[6];
            fo[2] = f[2];
        end
        return {fo, r[15:0]};
    endfunction

    // busy and done must never overlap
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap busy=%0b done=%0b required not both 1", busy, done);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result, f_out} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%0b done=%0b result=%h f_out=%h required all 0",
                     busy, done, result, f_out);
        end
        checks++;
        if ({alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in} !== 30'd0) begin
            errors++;
            $display("FAIL reset_alu_idle got=%h required 0",
                     {alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in});
        end
    endtask

    task automatic test_directed();
        int lat;
        logic got;
        logic [23:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            op = t_op[i]; opa = t_opa[i]; opb = t_opb[i]; f_in = t_fin[i]; start = 1'b1;
            @(posedge clk);
            #1;
            sb_q.push_back({t_fout[i], t_res[i]});
            start = 1'b0; op = ~op; opa = ~opa; opb = ~opb; f_in = ~f_in;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 8) begin
                @(negedge clk);
                lat++;
                if (i == 2 && lat == 1) begin
                    checks++;
                    if (alu_op !== 4'b0011) begin
                        errors++;
                        $display("FAIL sbc_lo_alu_op got=%b required 0011", alu_op);
                    end
                end
                if (i == 2 && lat == 2) begin
                    checks++;
                    if (alu_f_in[0] !== 1'b1) begin
                        errors++;
                        $display("FAIL sbc_hi_carry_in got=%b required 1", alu_f_in[0]);
                    end
                end
                if (done === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got || lat != 3) begin
                errors++;
                $display("FAIL directed_latency[%0d] cycles=%0d done_seen=%0b required 3", i, lat, got);
            end
            if (got && sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                checks++;
                if (result !== exp[15:0]) begin
                    errors++;
                    $display("FAIL directed_result[%0d] got=%h required %h", i, result, exp[15:0]);
                end
                checks++;
                if (f_out !== exp[23:16]) begin
                    errors++;
                    $display("FAIL directed_flags[%0d] got=%h required %h", i, f_out, exp[23:16]);
                end
            end else begin
                sb_q.delete();
            end
        end
    endtask

    task automatic test_back_to_back();
        int ph;
        logic [23:0] exp;
        ph = 0;
        @(posedge clk);
        #1;
        op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); f_in = 8'($urandom);
        start = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            if (ph == 0) begin
                if (start) begin
                    sb_q.push_back(ref16(op, opa, opb, f_in));
                    ph = 1;
                end
            end else begin
                ph = (ph == 3) ? 0 : ph + 1;
            end
            #1;
            op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom); f_in = 8'($urandom);
            start = (c < 9);
            @(negedge clk);
            checks++;
            if (busy !== (ph == 1 || ph == 2) || done !== (ph == 3)) begin
                errors++;
                $display("FAIL b2b_handshake cycle=%0d busy=%0b done=%0b required busy=%0b done=%0b",
                         c, busy, done, (ph == 1 || ph == 2), (ph == 3));
            end
            if (done === 1'b1 && sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                checks++;
                if ({f_out, result} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result cycle=%0d got f=%h r=%h required f=%h r=%h",
                             c, f_out, result, exp[23:16], exp[15:0]);
                end
            end
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain pending=%0d required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic got;
        logic [23:0] exp;
        @(posedge clk);
        #1;
        op = 2'b01; opa = 16'h1234; opb = 16'h1111; f_in = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result, f_out} !== 26'd0) begin
            errors++;
            $display("FAIL midreset_outputs busy=%0b done=%0b result=%h f_out=%h required all 0",
                     busy, done, result, f_out);
        end
        checks++;
        if ({alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in} !== 30'd0) begin
            errors++;
            $display("FAIL midreset_alu got=%h required 0",
                     {alu_op, alu_arith16, alu_z16, alu_busa, alu_busb, alu_f_in});
        end
        got = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL midreset_no_done got done=1 required none");
        end
        @(posedge clk);
        #1;
        op = 2'b00; opa = 16'h0FFF; opb = 16'h0001; f_in = 8'hC4; start = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back({8'hD4, 16'h1000});
        start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || lat != 3) begin
            errors++;
            $display("FAIL midreset_restart_latency cycles=%0d done_seen=%0b required 3", lat, got);
        end
        if (got && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            checks++;
            if ({f_out, result} !== exp) begin
                errors++;
                $display("FAIL midreset_restart_result got f=%h r=%h required f=%h r=%h",
                         f_out, result, exp[23:16], exp[15:0]);
            end
        end else begin
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        opa   = 16'h0000;
        opb   = 16'h0000;
        f_in  = 8'h00;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
